fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage with PC register, IF/ID pipeline
//               register, stall/redirect handling and HALT detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter int                      PC_WIDTH    = 8,
    parameter int                      INSTR_WIDTH = 19,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = 8'h00,
    parameter logic [4:0]              HALT_OPCODE = 5'h1F
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [PC_WIDTH-1:0]    pc,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_target,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0]    if_id_pc,
    output logic                   if_id_valid,
    output logic                   halted,
    output logic [15:0]            fetch_count
);

    localparam logic [PC_WIDTH-1:0] c_PC_INC    = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [15:0]         c_COUNT_MAX = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [PC_WIDTH-1:0]      r_pc;
    logic [PC_WIDTH-1:0]      w_pc_nxt;
    logic [INSTR_WIDTH-1:0]   r_instr;
    logic [INSTR_WIDTH-1:0]   w_instr_nxt;
    logic [PC_WIDTH-1:0]      r_ifpc;
    logic [PC_WIDTH-1:0]      w_ifpc_nxt;
    logic                     r_valid;
    logic                     w_valid_nxt;
    logic [15:0]              r_count;
    logic [15:0]              w_count_nxt;
    logic                     w_is_halt;

    assign w_is_halt = (instruction[INSTR_WIDTH-1 -: 5] == HALT_OPCODE);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_ifpc_nxt  = r_ifpc;
        w_valid_nxt = r_valid;
        w_count_nxt = r_count;
        if (redirect) begin
            w_pc_nxt    = redirect_target;
            w_instr_nxt = '0;
            w_ifpc_nxt  = '0;
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_RUN;
        end else if (!stall) begin
            case (r_state)
                ST_RUN: begin
                    w_instr_nxt = instruction;
                    w_ifpc_nxt  = r_pc;
                    w_valid_nxt = 1'b1;
                    w_count_nxt = (r_count == c_COUNT_MAX) ? r_count : r_count + 16'd1;
                    // The HALT word is delivered, but pc parks on its address.
                    if (w_is_halt) begin
                        w_state_nxt = ST_HALTED;
                    end else begin
                        w_pc_nxt = r_pc + c_PC_INC;
                    end
                end
                ST_HALTED: begin
                    w_instr_nxt = '0;
                    w_valid_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_ifpc  <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_ifpc  <= w_ifpc_nxt;
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign pc          = r_pc;
    assign if_id_instr = r_instr;
    assign if_id_pc    = r_ifpc;
    assign if_id_valid = r_valid;
    assign halted      = (r_state == ST_HALTED);
    assign fetch_count = r_count;

endmodule

`default_nettype wire
